// File: rtl/qos_scheduler.sv
// Four-class QoS buffer with weighted round-robin release on tx_tick.
// Define QOS_STRICT_PRIORITY_EN to give class 0 strict priority over WRR.
module qos_scheduler #(
    parameter int DEPTH = 6,
    parameter int W0 = 4,
    parameter int W1 = 3,
    parameter int W2 = 2,
    parameter int W3 = 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [3:0]      in_number,
    input  logic            in_valid,
    input  logic            tx_tick,
    output logic [3:0]      out_number,
    output logic            out_valid,
    output logic [4*CW-1:0] occupancy,
    output logic [11:0]     tx_count,
    output logic [11:0]     drop_count,
    output logic            empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    function automatic logic [7:0] weight(input logic [1:0] k);
        int w;
        case (k)
            2'd0:    w = W0;
            2'd1:    w = W1;
            2'd2:    w = W2;
            default: w = W3;
        endcase
        return (w == 0) ? 8'd1 : 8'(w);
    endfunction

    logic [3:0]    mem    [4][DEPTH];
    logic [PW-1:0] wr_ptr [4];
    logic [PW-1:0] rd_ptr [4];
    logic [CW-1:0] occ    [4];
    logic [CW-1:0] occ_n  [4];
    logic [1:0]    cur, cur_n, cls, deq_cls, k, idx;
    logic [7:0]    credit, credit_n;
    logic          enq, drop, deq, found, strict_hit, empty_n;

    always_comb begin
        cls  = in_number[3:2];
        enq  = in_valid && (occ[cls] != FULL);
        drop = in_valid && (occ[cls] == FULL);

        // first nonempty class after cur, wrapping back to cur last
        found = 1'b0;
        k     = cur;
        idx   = cur;
        for (int i = 1; i <= 4; i++) begin
            idx = cur + 2'(i);
            if (!found && occ[idx] != '0) begin
                found = 1'b1;
                k     = idx;
            end
        end

`ifdef QOS_STRICT_PRIORITY_EN
        strict_hit = (occ[0] != '0);
`else
        strict_hit = 1'b0;
`endif

        deq      = 1'b0;
        deq_cls  = cur;
        cur_n    = cur;
        credit_n = credit;
        if (tx_tick) begin
            if (strict_hit) begin
                deq     = 1'b1;
                deq_cls = 2'd0;
            end else if (occ[cur] != '0 && credit != 8'd0) begin
                deq      = 1'b1;
                deq_cls  = cur;
                credit_n = credit - 8'd1;
            end else if (found) begin
                deq      = 1'b1;
                deq_cls  = k;
                cur_n    = k;
                credit_n = weight(k) - 8'd1;
            end
        end

        empty_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            occ_n[i] = occ[i]
                     + CW'(enq && cls == 2'(i))
                     - CW'(deq && deq_cls == 2'(i));
            if (occ_n[i] != '0) empty_n = 1'b0;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_occ
        assign occupancy[g*CW +: CW] = occ[g];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                occ[i]    <= '0;
            end
            out_number <= '0;
            out_valid  <= 1'b0;
            tx_count   <= '0;
            drop_count <= '0;
            empty      <= 1'b1;
            cur        <= 2'd0;
            credit     <= weight(2'd0);
        end else begin
            if (enq) begin
                mem[cls][wr_ptr[cls]] <= in_number;
                wr_ptr[cls] <= (wr_ptr[cls] == LAST) ? '0 : wr_ptr[cls] + PW'(1);
            end
            if (drop) drop_count <= drop_count + 12'd1;
            out_valid <= deq;
            if (deq) begin
                out_number <= mem[deq_cls][rd_ptr[deq_cls]];
                rd_ptr[deq_cls] <= (rd_ptr[deq_cls] == LAST) ? '0
                                 : rd_ptr[deq_cls] + PW'(1);
                tx_count <= tx_count + 12'd1;
            end
            for (int i = 0; i < 4; i++) occ[i] <= occ_n[i];
            cur    <= cur_n;
            credit <= credit_n;
            empty  <= empty_n;
        end
    end

endmodule

// File: tb/tb_qos_scheduler.sv
// Directed scoreboard bench for qos_scheduler (default parameters).
module tb_qos_scheduler;

    localparam int CW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    in_number = '0;
    logic          in_valid = 1'b0;
    logic          tx_tick = 1'b0;
    logic [3:0]    out_number;
    logic          out_valid;
    logic [4*CW-1:0] occupancy;
    logic [11:0]   tx_count;
    logic [11:0]   drop_count;
    logic          empty;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic exp_vld = 1'b0;
    logic mon_en = 1'b0;

    always #5 clock = ~clock;

    qos_scheduler dut (
        .clock(clock),
        .reset(reset),
        .in_number(in_number),
        .in_valid(in_valid),
        .tx_tick(tx_tick),
        .out_number(out_number),
        .out_valid(out_valid),
        .occupancy(occupancy),
        .tx_count(tx_count),
        .drop_count(drop_count),
        .empty(empty)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            chk("out_valid", 32'(out_valid), 32'(exp_vld));
            if (out_valid === 1'b1 && exp_vld && exp_q.size() != 0)
                chk("out_number", 32'(out_number), 32'(exp_q.pop_front()));
        end
    end

    // one clock of stimulus; srv pushes the number the tick must release
    task automatic cyc(input logic iv, input logic [3:0] num,
                       input logic tk, input logic srv,
                       input logic [3:0] expn);
        in_valid  = iv;
        in_number = num;
        tx_tick   = tk;
        if (srv) exp_q.push_back(expn);
        @(posedge clock);
        #1;
        exp_vld  = srv;
        in_valid = 1'b0;
        tx_tick  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic do_reset;
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        reset  = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_number", 32'(out_number), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_tx_count", 32'(tx_count), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        reset = 1'b0;
        exp_q.delete();
        exp_vld = 1'b0;
        mon_en  = 1'b1;
    endtask

    int ord[12] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3, 0, 0};
    int nxt[4];

    initial begin
        // 1: random traffic, then reset
        do_reset();
        mon_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_number = 4'($urandom);
            tx_tick   = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        tx_tick  = 1'b0;
        do_reset();

        // 2: two entries, ticks three cycles apart
        cyc(1'b1, 4'h1, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 4'h6, 1'b0, 1'b0, 4'h0);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'h1);
        idle(2);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'h6);
        idle(1);
        chk("t2_tx_count", 32'(tx_count), 32'd2);
        chk("t2_empty", 32'(empty), 32'd1);

        // 3: overflow class 2, drain in order, then reuse wrapped slot
        cyc(1'b1, 4'h8, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 4'h9, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 4'hA, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 4'hB, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 4'h8, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 4'h9, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 4'hA, 1'b0, 1'b0, 4'h0);
        chk("t3_occ2", 32'(occupancy[2*CW +: CW]), 32'd6);
        chk("t3_drop", 32'(drop_count), 32'd1);
        chk("t3_not_empty", 32'(empty), 32'd0);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'h8);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'h9);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'hA);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'hB);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'h8);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'h9);
        idle(1);
        cyc(1'b1, 4'hB, 1'b0, 1'b0, 4'h0);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'hB);
        idle(1);
        chk("t3_tx_count", 32'(tx_count), 32'd9);
        chk("t3_empty", 32'(empty), 32'd1);

        // 4: all classes loaded, WRR order with default weights
        do_reset();
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 6; j++)
                cyc(1'b1, 4'(c * 4 + j % 4), 1'b0, 1'b0, 4'h0);
        chk("t4_occ", 32'(occupancy), 32'h0db6);
        for (int c = 0; c < 4; c++) nxt[c] = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'(ord[i] * 4 + nxt[ord[i]] % 4));
            nxt[ord[i]]++;
        end
        idle(1);
        chk("t4_tx_count", 32'(tx_count), 32'd12);

        // full class with same-cycle enqueue and dequeue still drops
        do_reset();
        cyc(1'b1, 4'hC, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 4'hD, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 4'hE, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 4'hF, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 4'hC, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 4'hD, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 4'hE, 1'b1, 1'b1, 4'hC);
        idle(1);
        chk("full_drop", 32'(drop_count), 32'd1);
        chk("full_occ3", 32'(occupancy[3*CW +: CW]), 32'd5);

        // 5: same-cycle enqueue on empty is not eligible
        do_reset();
        cyc(1'b1, 4'hC, 1'b1, 1'b0, 4'h0);
        idle(1);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'hC);
        idle(1);
        chk("t5_tx_count", 32'(tx_count), 32'd1);
        chk("t5_empty", 32'(empty), 32'd1);

`ifdef QOS_STRICT_PRIORITY_EN
        // 6: class 0 preempts a class 1 burst without losing its credit
        do_reset();
        cyc(1'b1, 4'h4, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 4'h5, 1'b0, 1'b0, 4'h0);
        cyc(1'b1, 4'h6, 1'b0, 1'b0, 4'h0);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'h4);
        cyc(1'b1, 4'h2, 1'b0, 1'b0, 4'h0);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'h2);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'h5);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 4'h6);
        idle(1);
        chk("t6_empty", 32'(empty), 32'd1);
`endif

        idle(2);
        chk("sb_final", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qos_scheduler.md
Name: qos_scheduler

Overview:
- Four-class QoS buffer and weighted round-robin (WRR) scheduler.
- Sits between the button-driven 4-bit number entry block and the display/output stage.
- Each accepted 4-bit number is classified by its upper two bits and stored in a per-class circular FIFO.
- On every transmit tick, one stored number is released according to per-class weights.

Parameters:
- DEPTH, 6, entries per class FIFO (2..15; need not be a power of two).
- W0, 4, WRR weight of class 0 (value 0 is treated as 1).
- W1, 3, WRR weight of class 1.
- W2, 2, WRR weight of class 2.
- W3, 1, WRR weight of class 3.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_number  in  4  number from the entry block; bits[3:2] = class (0 = highest), bits[1:0] = payload.
- in_valid  in  1  single-cycle strobe qualifying in_number.
- tx_tick  in  1  single-cycle strobe requesting one dequeue.
- out_number  out  4  released number (full 4 bits, class included).
- out_valid  out  1  single-cycle strobe qualifying out_number.
- occupancy  out  4*CW  per-class fill level; class k in bits [k*CW +: CW], where CW = clog2(DEPTH+1).
- tx_count  out  12  total numbers released; wraps modulo 4096.
- drop_count  out  12  total numbers dropped; wraps modulo 4096.
- empty  out  1  high when all four FIFOs are empty.

Behaviour:
- Reset (synchronous, active-high):
  - All FIFOs emptied: pointers and occupancy = 0.
  - out_number = 0, out_valid = 0, tx_count = 0, drop_count = 0, empty = 1.
  - WRR pointer cur = 0, credit = W0.
  - Reset asserted mid-operation discards all stored entries; pending strobes in that cycle are ignored.
- Enqueue (in_valid = 1):
  - Class c = in_number[3:2].
  - If occ[c] < DEPTH: write in_number at wr_ptr[c], advance wr_ptr[c] (wraps DEPTH-1 -> 0), occ[c] += 1.
  - Else: entry is discarded and drop_count += 1.
- Dequeue (tx_tick = 1):
  - Decision uses occupancy at the start of the cycle; an entry enqueued in the same cycle is not eligible.
  - Rule A: if occ[cur] != 0 and credit != 0, serve cur; credit -= 1.
  - Rule B: otherwise scan classes cur+1, cur+2, cur+3, cur (mod 4) for the first nonempty class k; serve k; cur <= k; credit <= max(W[k],1) - 1.
  - If all FIFOs are empty: no output; cur and credit are unchanged.
- Serve:
  - out_number <= entry at rd_ptr[k], out_valid <= 1 for exactly one cycle.
  - rd_ptr[k] advances with wrap; occ[k] -= 1; tx_count += 1.
- Latency: tx_tick in cycle N -> out_valid in cycle N+1. out_number holds its last value while out_valid = 0.
- Simultaneous events:
  - in_valid and tx_tick in the same cycle: both take effect.
  - Same class, full FIFO: the enqueue is still dropped (fullness is judged before the dequeue), even though the dequeue frees a slot.
  - Same class, not full: occ[k] is unchanged net.
- empty and occupancy are registered and reflect state after the current edge.
- The block has no backpressure. The downstream stage must accept every out_valid pulse.

Optional Feature:
- Macro: QOS_STRICT_PRIORITY_EN.
- Defined: if occ[0] != 0 at a tx_tick, class 0 is served unconditionally. cur and credit are left untouched, so the WRR sequence resumes where it stopped once class 0 drains. WRR applies to classes 1..3 only.
- Undefined: pure WRR across all four classes as described above.

Test Plan:
1. Assert reset for 2 cycles after random traffic -> out_valid = 0, out_number = 0, occupancy = 0, tx_count = 0, drop_count = 0, empty = 1.
2. Enqueue 4'h1 then 4'h6, then two tx_ticks 3 cycles apart -> out_number 4'h1 then 4'h6, each out_valid exactly one cycle after its tick; tx_count = 2; empty = 1.
3. Enqueue seven class-2 numbers (4'h8..4'hB, 4'h8, 4'h9, 4'hA) -> occupancy class 2 = 6, drop_count = 1; six ticks drain 4'h8, 4'h9, 4'hA, 4'hB, 4'h8, 4'h9 in order (verifies wrap).
4. Load 6 entries in each class with default weights, then issue 10 ticks -> served class order 0,0,0,0,1,1,1,2,2,3.
5. All FIFOs empty; in_valid with 4'hC and tx_tick in the same cycle -> no out_valid; next tick -> out_number 4'hC.
6. With QOS_STRICT_PRIORITY_EN: class 1 mid-burst, then enqueue 4'h2 -> next tick serves 4'h2; following ticks resume class 1 with its remaining credit intact.
